// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Data-memory responder for the pipelined core. It reads
//               combinationally, writes with byte enables, and logs every
//               committed store in a drainable FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LOG_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        addr_err
);

  localparam int          c_addr_w = $clog2(DEPTH_WORDS);
  localparam int          c_lptr_w = $clog2(LOG_DEPTH);
  localparam logic [31:0] c_limit  = 32'(4 * DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] r_log_pc   [LOG_DEPTH];
  logic [31:0] r_log_addr [LOG_DEPTH];
  logic [31:0] r_log_data [LOG_DEPTH];

  logic [c_lptr_w:0] r_wr_ptr;
  logic [c_lptr_w:0] r_rd_ptr;
  logic              r_overflow;
  logic              r_addr_err;

  logic [c_addr_w-1:0] w_index;
  logic                w_in_range;
  logic                w_store_req;
  logic [31:0]         w_old;
  logic [31:0]         w_merged;
  logic                w_commit;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  assign w_index    = m_data_addr[c_addr_w+1:2];
  assign w_in_range = (m_data_addr < c_limit);
  assign w_old      = w_in_range ? r_mem[w_index] : 32'h0;

  // Enables evaluated bit by bit with if, so an unknown enable counts as off.
  always_comb begin
    w_store_req = 1'b0;
    w_merged    = w_old;
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) begin
        w_store_req       = 1'b1;
        w_merged[8*k +: 8] = m_data_wdata[8*k +: 8];
      end
    end
  end

  assign w_commit = w_store_req && w_in_range;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_lptr_w-1:0] == r_rd_ptr[c_lptr_w-1:0]) &&
                   (r_wr_ptr[c_lptr_w] != r_rd_ptr[c_lptr_w]);
  assign w_pop   = !w_empty && log_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_commit && (!w_full || w_pop);

  assign m_data_rdata = w_old;
  assign log_valid    = !w_empty;
  assign log_pc       = w_empty ? 32'h0 : r_log_pc[r_rd_ptr[c_lptr_w-1:0]];
  assign log_addr     = w_empty ? 32'h0 : r_log_addr[r_rd_ptr[c_lptr_w-1:0]];
  assign log_data     = w_empty ? 32'h0 : r_log_data[r_rd_ptr[c_lptr_w-1:0]];
  assign log_overflow = r_overflow;
  assign addr_err     = r_addr_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'h0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_commit) begin
        r_mem[w_index] <= w_merged;
      end
      if (w_push) begin
        r_log_pc[r_wr_ptr[c_lptr_w-1:0]]   <= m_inst_addr;
        r_log_addr[r_wr_ptr[c_lptr_w-1:0]] <= {m_data_addr[31:2], 2'b00};
        r_log_data[r_wr_ptr[c_lptr_w-1:0]] <= w_merged;
        r_wr_ptr <= r_wr_ptr + (c_lptr_w+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (c_lptr_w+1)'(1);
      end
      if (w_commit && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      r_addr_err <= w_store_req && !w_in_range;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder: directed scenarios with
//               literal expectations plus randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

  localparam int c_depth = 3072;
  localparam int c_logd  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic        addr_err;

  dm_responder #(.DEPTH_WORDS(c_depth), .LOG_DEPTH(c_logd)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_inst_addr  (m_inst_addr),
    .m_data_rdata (m_data_rdata),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_pc       (log_pc),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_mem [c_depth];
  ent_t        m_q[$];
  logic        m_ovf;
  logic        m_aerr;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy, input logic rst);
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    m_inst_addr   = pc;
    log_ready     = rdy;
    reset         = rst;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model by one edge.
  task automatic tick(input bit do_cmp);
    logic        inr;
    logic [31:0] old_w;
    logic [31:0] merged;
    ent_t        head;
    int          idx;
    @(negedge clk);
    inr   = (m_data_addr < 32'(4 * c_depth));
    idx   = int'(m_data_addr[13:2]);
    old_w = inr ? m_mem[idx] : 32'h0;
    head  = (m_q.size() > 0) ? m_q[0] : '0;
    if (do_cmp) begin
      check("rdata", m_data_rdata, old_w);
      check("log_valid", 32'(log_valid), 32'(m_q.size() > 0));
      check("log_pc", log_pc, head.pc);
      check("log_addr", log_addr, head.addr);
      check("log_data", log_data, head.data);
      check("log_overflow", 32'(log_overflow), 32'(m_ovf));
      check("addr_err", 32'(addr_err), 32'(m_aerr));
    end
    if (reset) begin
      for (int i = 0; i < c_depth; i++) m_mem[i] = 32'h0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_aerr = 1'b0;
    end else begin
      if (m_q.size() > 0 && log_ready) void'(m_q.pop_front());
      if (m_data_byteen != 4'h0 && inr) begin
        for (int k = 0; k < 4; k++)
          merged[8*k +: 8] = m_data_byteen[k] ? m_data_wdata[8*k +: 8] : old_w[8*k +: 8];
        m_mem[idx] = merged;
        if (m_q.size() < c_logd) m_q.push_back({m_inst_addr, {m_data_addr[31:2], 2'b00}, merged});
        else m_ovf = 1'b1;
      end
      m_aerr = (m_data_byteen != 4'h0) && !inr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(32'h0, 32'h0, 4'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    tick(1);
  endtask

  task automatic drain_count(output int n);
    n = 0;
    idle(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (log_valid) n++;
      tick(1);
    end
  endtask

  int n;
  logic [31:0] ra;
  logic [3:0]  rb;

  initial begin
    m_ovf  = 1'b0;
    m_aerr = 1'b0;
    for (int i = 0; i < c_depth; i++) m_mem[i] = 32'h0;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    tick(0);
    do_reset();
    idle(1'b0);
    #1;
    check("reset log_valid", 32'(log_valid), 32'h0);
    check("reset overflow", 32'(log_overflow), 32'h0);
    check("reset addr_err", 32'(addr_err), 32'h0);
    check("reset rdata", m_data_rdata, 32'h0);

    // Full-word store, old value visible during the store cycle.
    drive(32'h10, 32'h12345678, 4'hF, 32'h100, 1'b0, 1'b0);
    #1 check("sw same-cycle rdata", m_data_rdata, 32'h0);
    tick(1);
    drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    #1 check("sw next rdata", m_data_rdata, 32'h12345678);
    tick(1);

    // Byte merge and in-order log.
    drive(32'h20, 32'hAABBCCDD, 4'hF, 32'h200, 1'b0, 1'b0); tick(1);
    drive(32'h20, 32'h11111111, 4'h4, 32'h204, 1'b0, 1'b0); tick(1);
    drive(32'h20, 32'h22222222, 4'h3, 32'h208, 1'b0, 1'b0); tick(1);
    drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    #1 check("merge rdata", m_data_rdata, 32'hAA112222);
    check("log head0", log_data, 32'hAABBCCDD);
    tick(1);
    check("log head1", log_data, 32'hAA11CCDD);
    tick(1);
    check("log head2", log_data, 32'hAA112222);
    check("log head2 pc", log_pc, 32'h208);
    tick(1);
    check("log drained", 32'(log_valid), 32'h0);

    // Log content with a single high-byte store.
    drive(32'h7, 32'h9F123456, 4'h8, 32'h3008, 1'b0, 1'b0); tick(1);
    idle(1'b0);
    #1 check("sb log_pc", log_pc, 32'h3008);
    check("sb log_addr", log_addr, 32'h4);
    check("sb log_data", log_data, 32'h9F000000);
    drain_count(n);

    // Overflow: nine stores with no consumer.
    for (int i = 0; i < 9; i++) begin
      drive(32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
      tick(1);
    end
    idle(1'b0);
    #1 check("ovf log_valid", 32'(log_valid), 32'h1);
    check("ovf flag", 32'(log_overflow), 32'h1);
    drain_count(n);
    check("ovf drain count", 32'(n), 32'h8);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(32'h200 + 32'(4 * i), 32'(i), 4'hF, 32'h500, 1'b0, 1'b0);
      tick(1);
    end
    drive(32'h300, 32'h55, 4'hF, 32'h600, 1'b1, 1'b0); tick(1);
    idle(1'b0);
    #1 check("full pushpop head", log_addr, 32'h204);
    check("full pushpop ovf", 32'(log_overflow), 32'h0);
    drain_count(n);
    check("full pushpop count", 32'(n), 32'h8);

    // Out-of-range store.
    drive(32'h3000, 32'hFFFFFFFF, 4'hF, 32'h700, 1'b1, 1'b0); tick(1);
    idle(1'b1);
    #1 check("oor addr_err", 32'(addr_err), 32'h1);
    check("oor no log", 32'(log_valid), 32'h0);
    tick(1);
    check("oor addr_err pulse", 32'(addr_err), 32'h0);

    // Reset with queued entries and a concurrent store.
    for (int i = 0; i < 3; i++) begin
      drive(32'h40 + 32'(4 * i), 32'hABCD0000, 4'hF, 32'h800, 1'b0, 1'b0);
      tick(1);
    end
    drive(32'h60, 32'h77777777, 4'hF, 32'h900, 1'b0, 1'b1); tick(1);
    drive(32'h60, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1 check("rst log_valid", 32'(log_valid), 32'h0);
    check("rst store dropped", m_data_rdata, 32'h0);
    drive(32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1 check("rst mem cleared", m_data_rdata, 32'h0);
    tick(1);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        7:       ra = 32'h2FFC + 32'($urandom_range(0, 3));
        8:       ra = 32'h3000 + 32'($urandom_range(0, 15));
        9:       ra = $urandom;
        default: ra = 32'($urandom_range(0, 63));
      endcase
      rb = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom);
      drive(ra, $urandom, rb, $urandom, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 99) == 0));
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
